// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// hazard_unit -- stall/flush/forward control for the 5-stage MIPS pipeline,
// with multiplier-busy tracking, a busy watchdog and a stall-cycle counter.
// Revision: 1.0
// ============================================================================
module hazard_unit #(
  parameter int MULT_TIMEOUT = 64,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             branchD,
  input  logic [4:0]             RsD,
  input  logic [4:0]             RtD,
  input  logic                   RegWriteE,
  input  logic                   RegWriteM,
  input  logic                   RegWriteW,
  input  logic [2:0]             WBSrcE,
  input  logic [2:0]             WBSrcM,
  input  logic [4:0]             RsE,
  input  logic [4:0]             RtE,
  input  logic [4:0]             WriteRegE,
  input  logic [4:0]             WriteRegM,
  input  logic [4:0]             WriteRegW,
  input  logic                   MultStartE,
  input  logic                   MultDoneE,
  output logic                   stallF,
  output logic                   stallD,
  output logic                   flushE,
  output logic                   forwardAD,
  output logic                   forwardBD,
  output logic [1:0]             forwardAE,
  output logic [1:0]             forwardBE,
  output logic                   mult_timeout,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int WD_W = $clog2(MULT_TIMEOUT + 1);
  localparam logic [2:0] SRC_LOAD = 3'b001;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state, state_next;

  logic [WD_W-1:0]        wd_cnt;
  logic                   timeout_flag;
  logic [STALL_CNT_W-1:0] stall_cnt;

  logic lwstall, branchstall, multstall, stall;
  logic hitE_s, hitE_t, hitM_s, hitM_t;

  // A write to $0 is architecturally discarded, so it never matches.
  function automatic logic reg_match(input logic we, input logic [4:0] wr,
                                     input logic [4:0] r);
    return we && (wr == r) && (r != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                         input logic weM, input logic [4:0] wrM,
                                         input logic weW, input logic [4:0] wrW);
    if (reg_match(weM, wrM, r))
      return 2'b10;
    else if (reg_match(weW, wrW, r))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    hitE_s = reg_match(RegWriteE, WriteRegE, RsD);
    hitE_t = reg_match(RegWriteE, WriteRegE, RtD);
    hitM_s = reg_match(RegWriteM, WriteRegM, RsD);
    hitM_t = reg_match(RegWriteM, WriteRegM, RtD);

    lwstall     = (WBSrcE == SRC_LOAD) && (hitE_s || hitE_t);
    branchstall = (branchD != 2'b00) &&
                  ((hitE_s || hitE_t) ||
                   ((WBSrcM == SRC_LOAD) && (hitM_s || hitM_t)));
    multstall   = (state == IDLE) ? (MultStartE && !MultDoneE) : !MultDoneE;

    stall = !rst && (lwstall || branchstall || multstall);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (MultStartE && !MultDoneE) state_next = BUSY;
      BUSY:    if (MultDoneE) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stallF       = stall;
    stallD       = stall;
    flushE       = stall;
    forwardAD    = 1'b0;
    forwardBD    = 1'b0;
    forwardAE    = 2'b00;
    forwardBE    = 2'b00;
    mult_timeout = 1'b0;
    stall_cycles = '0;
    if (!rst) begin
      forwardAD    = hitM_s;
      forwardBD    = hitM_t;
      forwardAE    = fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
      forwardBE    = fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
      mult_timeout = timeout_flag;
      stall_cycles = stall_cnt;
    end
  end

  // Watchdog holds at MULT_TIMEOUT so it cannot wrap during a hung multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wd_cnt       <= '0;
      timeout_flag <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (state_next == BUSY)
          wd_cnt <= '0;
      end else begin
        if (wd_cnt != WD_W'(MULT_TIMEOUT))
          wd_cnt <= wd_cnt + WD_W'(1);
        if (wd_cnt >= WD_W'(MULT_TIMEOUT - 1))
          timeout_flag <= 1'b1;
      end
      if (stall && (stall_cnt != {STALL_CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// tb_hazard_unit -- directed checks plus randomized traffic compared every
// cycle against a behavioural model of the hazard rules.
module tb_hazard_unit;

  localparam int TMO   = 8;
  localparam int CW    = 8;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    branchD;
  logic [4:0]    RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic          RegWriteE, RegWriteM, RegWriteW;
  logic [2:0]    WBSrcE, WBSrcM;
  logic          MultStartE, MultDoneE;
  logic          stallF, stallD, flushE, forwardAD, forwardBD, mult_timeout;
  logic [1:0]    forwardAE, forwardBE;
  logic [CW-1:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit m_busy    = 0;
  int m_busycyc = 0;
  bit m_tmo     = 0;
  int m_cnt     = 0;

  hazard_unit #(.MULT_TIMEOUT(TMO), .STALL_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .branchD(branchD), .RsD(RsD), .RtD(RtD),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .WBSrcE(WBSrcE), .WBSrcM(WBSrcM), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .MultStartE(MultStartE), .MultDoneE(MultDoneE),
    .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .mult_timeout(mult_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hit(input bit we, input int wr, input int r);
    return we && wr == r && r != 0;
  endfunction

  function automatic int fwd(input int r);
    if (hit(RegWriteM, WriteRegM, r)) return 2;
    if (hit(RegWriteW, WriteRegW, r)) return 1;
    return 0;
  endfunction

  function automatic bit m_stall();
    bit e_hit, m_hit, mult;
    if (rst) return 0;
    e_hit = hit(RegWriteE, WriteRegE, RsD) || hit(RegWriteE, WriteRegE, RtD);
    m_hit = hit(RegWriteM, WriteRegM, RsD) || hit(RegWriteM, WriteRegM, RtD);
    mult  = m_busy ? !MultDoneE : (MultStartE && !MultDoneE);
    return (WBSrcE == 3'd1 && e_hit) ||
           (branchD != 0 && (e_hit || (WBSrcM == 3'd1 && m_hit))) || mult;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_busycyc = 0; m_tmo = 0; m_cnt = 0;
    end else begin
      if (m_stall() && m_cnt < CMAX) m_cnt = m_cnt + 1;
      if (m_busy) begin
        m_busycyc = m_busycyc + 1;
        if (m_busycyc >= TMO) m_tmo = 1;
        if (MultDoneE) m_busy = 0;
      end else if (MultStartE && !MultDoneE) begin
        m_busy = 1; m_busycyc = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit s;
    s = m_stall();
    chk("stallF", stallF, s);
    chk("stallD", stallD, s);
    chk("flushE", flushE, s);
    chk("forwardAE", forwardAE, rst ? 0 : fwd(RsE));
    chk("forwardBE", forwardBE, rst ? 0 : fwd(RtE));
    chk("forwardAD", forwardAD, rst ? 0 : int'(hit(RegWriteM, WriteRegM, RsD)));
    chk("forwardBD", forwardBD, rst ? 0 : int'(hit(RegWriteM, WriteRegM, RtD)));
    chk("mult_timeout", mult_timeout, rst ? 0 : int'(m_tmo));
    chk("stall_cycles", stall_cycles, rst ? 0 : m_cnt);
  end

  task automatic idle_inputs();
    branchD = 0; RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    WBSrcE = 0; WBSrcM = 0; WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    MultStartE = 0; MultDoneE = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs(); tick();
    rst = 0; #2;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    RegWriteM = 1; WriteRegM = 8; RsE = 8; MultStartE = 1;
    #2;
    chk("reset_fwdAE", forwardAE, 0);
    chk("reset_stall", stallD, 0);
    chk("reset_cnt", stall_cycles, 0);
    tick(); tick();
    do_reset();

    // Forwarding
    RegWriteM = 1; WriteRegM = 8; RsE = 8; #2;
    chk("fwd_M", forwardAE, 2);
    RegWriteM = 0; RegWriteW = 1; WriteRegW = 8; #2;
    chk("fwd_W", forwardAE, 1);
    RegWriteM = 1; WriteRegM = 8; #2;
    chk("fwd_M_over_W", forwardAE, 2);
    RsE = 0; WriteRegM = 0; WriteRegW = 0; #2;
    chk("fwd_r0", forwardAE, 0);
    tick();

    // Load-use
    do_reset();
    WBSrcE = 1; RegWriteE = 1; WriteRegE = 9; RtD = 9; #2;
    chk("lw_stall", stallD, 1);
    chk("lw_flush", flushE, 1);
    tick();
    WBSrcE = 0; #2;
    chk("lw_clear", stallF, 0);
    chk("lw_cnt", stall_cycles, 1);
    tick();

    // Branch
    idle_inputs();
    branchD = 1; RsD = 4; RegWriteE = 1; WriteRegE = 4; #2;
    chk("br_stallE", stallD, 1);
    tick();
    RegWriteE = 0; RegWriteM = 1; WriteRegM = 4; WBSrcM = 0; #2;
    chk("br_stallM", stallD, 0);
    chk("br_fwdAD", forwardAD, 1);
    tick();

    // Multiply, 5-cycle latency
    do_reset();
    MultStartE = 1; #2;
    chk("mul_stall_t0", stallD, 1);
    tick();
    MultStartE = 0;
    for (int i = 1; i < 5; i++) begin
      #2; chk("mul_stall_busy", stallD, 1); tick();
    end
    MultDoneE = 1; #2;
    chk("mul_done_nostall", stallD, 0);
    tick();
    MultDoneE = 0; #2;
    chk("mul_idle_after", stallD, 0);
    chk("mul_cnt", stall_cycles, 5);
    tick();

    // Simultaneous start and done in IDLE
    MultStartE = 1; MultDoneE = 1; #2;
    chk("mul_simul", stallD, 0);
    tick();
    MultStartE = 0; MultDoneE = 0; #2;
    chk("mul_simul_idle", stallD, 0);
    tick();

    // Timeout, then reset mid-multiply
    do_reset();
    MultStartE = 1; tick();
    MultStartE = 0;
    for (int i = 1; i <= TMO; i++) begin
      #2; chk("tmo_not_yet", mult_timeout, 0); tick();
    end
    #2; chk("tmo_set", mult_timeout, 1);
    tick(); tick(); tick();
    #2; chk("tmo_sticky", mult_timeout, 1);
    chk("tmo_still_busy", stallD, 1);
    rst = 1; #2;
    chk("rst_tmo", mult_timeout, 0);
    chk("rst_stall", stallD, 0);
    chk("rst_cnt", stall_cycles, 0);
    tick();
    rst = 0; MultDoneE = 1; #2;
    chk("post_rst_stall", stallD, 0);
    tick();
    MultDoneE = 0; #2;
    chk("post_rst_idle", stallD, 0);
    chk("post_rst_tmo", mult_timeout, 0);
    tick();

    // Counter saturation
    do_reset();
    WBSrcE = 1; RegWriteE = 1; WriteRegE = 7; RsD = 7;
    for (int i = 0; i < CMAX + 20; i++) tick();
    #2; chk("cnt_saturate", stall_cycles, CMAX);
    tick();

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rst        = ($urandom_range(0, 149) == 0);
      branchD    = 2'($urandom_range(0, 3));
      RsD        = 5'($urandom_range(0, 3));
      RtD        = 5'($urandom_range(0, 3));
      RsE        = 5'($urandom_range(0, 3));
      RtE        = 5'($urandom_range(0, 3));
      WriteRegE  = 5'($urandom_range(0, 3));
      WriteRegM  = 5'($urandom_range(0, 3));
      WriteRegW  = 5'($urandom_range(0, 3));
      RegWriteE  = 1'($urandom_range(0, 1));
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      WBSrcE     = 3'($urandom_range(0, 4));
      WBSrcM     = 3'($urandom_range(0, 4));
      MultStartE = !m_busy && ($urandom_range(0, 7) == 0);
      MultDoneE  = ($urandom_range(0, 5) == 0);
      tick();
    end

    idle_inputs();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage MIPS core. It consumes the hazard-status outputs the datapath exports (register specifiers, write enables, write-back source selects, branch and multiplier flags) and returns the stall, flush and forwarding controls the datapath accepts. Forwarding and stall decisions are combinational. A multiplier-busy state machine, a timeout watchdog and a stall-cycle counter are registered.

## Interface
- MULT_TIMEOUT, 64: max cycles in BUSY before `mult_timeout` sets.
- STALL_CNT_W, 16: width of `stall_cycles`.

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- branchD  in  2  branch in D (00 none, 01 beq, 10 bne)
- RsD, RtD  in  5 each  D-stage source registers
- RegWriteE, RegWriteM, RegWriteW  in  1 each  stage write enables
- WBSrcE, WBSrcM  in  3 each  write-back source: 000 ALU, 001 memory load, 010 PC+8, 011 LO, 100 HI
- RsE, RtE  in  5 each  E-stage source registers
- WriteRegE, WriteRegM, WriteRegW  in  5 each  stage destination registers
- MultStartE  in  1  multiply issued from E this cycle
- MultDoneE  in  1  multiplier result valid this cycle
- stallF, stallD  out  1 each  hold PC / D register
- flushE  out  1  clear E register (bubble)
- forwardAD, forwardBD  out  1 each  D-stage compare operand from M
- forwardAE, forwardBE  out  2 each  E operand: 00 regfile, 01 W result, 10 M result
- mult_timeout  out  1  sticky error flag
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with stallD=1

## Operation
- Define `mE(r) = RegWriteE && WriteRegE==r && r!=0`. Define `mM(r)` and `mW(r)` the same way.
- forwardAE = 10 if mM(RsE); otherwise 01 if mW(RsE); otherwise 00. M takes priority over W. forwardBE is the same on RtE.
- forwardAD = mM(RsD). forwardBD = mM(RtD).
- lwstall = WBSrcE==001 && mE(RsD or RtD).
- branchstall = branchD!=00 && (mE(RsD or RtD) || (WBSrcM==001 && mM(RsD or RtD))).
- Multiplier FSM, two states:
  - IDLE→BUSY on MultStartE && !MultDoneE.
  - BUSY→IDLE on MultDoneE.
  - MultStartE while in BUSY is ignored. It is a protocol violation and asserting it is a bench error.
- multstall = (IDLE && MultStartE && !MultDoneE) || (BUSY && !MultDoneE).
- stall = lwstall || branchstall || multstall. stallF = stallD = flushE = stall.
- Watchdog counter:
  - Clears on entry to BUSY and increments each cycle in BUSY.
  - When it reaches MULT_TIMEOUT, mult_timeout sets and stays set until rst.
  - The FSM does not leave BUSY on timeout.
- stall_cycles increments by 1 each cycle stallD=1 and saturates at all-ones.

## Timing
- All hazard outputs are combinational from the current inputs and the registered FSM state. There is no added latency.
- While rst=1, every output is 0: stalls, flush, forwards, mult_timeout, stall_cycles.
- At the first edge with rst=1, the FSM goes to IDLE and the watchdog counter, mult_timeout and stall_cycles clear.
- Reset mid-multiply: the FSM returns to IDLE, and any MultDoneE afterwards is ignored.
- Multiply stall length:
  - With MultStartE in cycle t and MultDoneE in cycle t+k (k≥1), stall is 1 for cycles t..t+k-1 and 0 in cycle t+k.
  - The FSM is BUSY from t+1 through t+k and IDLE from t+k+1.
- Simultaneous MultStartE && MultDoneE in IDLE: no stall, remain IDLE.
- Register $0 never forwards and never stalls.
- When both M and W match, M wins.

## Test plan
- Forwarding:
  - RegWriteM=1, WriteRegM=8, RsE=8 → forwardAE=10.
  - Then RegWriteM=0, RegWriteW=1, WriteRegW=8 → forwardAE=01.
  - RsE=0, WriteRegM=0, RegWriteM=1 → forwardAE=00.
- Load-use: WBSrcE=001, RegWriteE=1, WriteRegE=9, RtD=9 → stallF=stallD=flushE=1 for one cycle. Next cycle with WBSrcE=000 → all 0. stall_cycles increments by 1.
- Branch: branchD=01, RsD=4, RegWriteE=1, WriteRegE=4 → stall=1. Move the producer to M as an ALU op → stall=0, forwardAD=1.
- Multiply: MultStartE pulse at t, MultDoneE at t+5 → stall high for exactly 5 cycles, FSM IDLE at t+6, stall_cycles=5.
- Timeout and reset: MULT_TIMEOUT=8, MultStartE with no MultDoneE → mult_timeout=1 after 8 BUSY cycles and remains set. Assert rst for one cycle → all outputs 0 and FSM IDLE.
